// File: rtl/mem_pkg.sv
// Shared constants and types for the data memory responder: RV32I funct3 codes,
// FSM state type and the request legality check used by the parent.
package mem_pkg;

  localparam logic [2:0] Funct3Lb  = 3'b000;
  localparam logic [2:0] Funct3Lh  = 3'b001;
  localparam logic [2:0] Funct3Lw  = 3'b010;
  localparam logic [2:0] Funct3Lbu = 3'b100;
  localparam logic [2:0] Funct3Lhu = 3'b101;
  localparam logic [2:0] Funct3Sb  = 3'b000;
  localparam logic [2:0] Funct3Sh  = 3'b001;
  localparam logic [2:0] Funct3Sw  = 3'b010;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  // Misaligned, unknown funct3 or simultaneous load+store all count as errors.
  function automatic logic req_illegal(input logic rd, input logic wr,
                                       input logic [2:0] f3, input logic [1:0] a);
    logic err;
    err = 1'b0;
    if (rd && wr) begin
      err = 1'b1;
    end else if (rd) begin
      case (f3)
        Funct3Lb, Funct3Lbu: err = 1'b0;
        Funct3Lh, Funct3Lhu: err = a[0];
        Funct3Lw:            err = |a;
        default:             err = 1'b1;
      endcase
    end else if (wr) begin
      case (f3)
        Funct3Sb: err = 1'b0;
        Funct3Sh: err = a[0];
        Funct3Sw: err = |a;
        default:  err = 1'b1;
      endcase
    end
    return err;
  endfunction

endpackage

// File: rtl/dm_sram.sv
// Word-organised data array with per-byte write enables and a registered read port.
module dm_sram #(
  parameter int unsigned Depth = 128,
  parameter int unsigned AddrW = 7
) (
  input  logic             clk_i,
  input  logic             en_i,
  input  logic [3:0]       be_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [Depth];
  logic [31:0] rdata_q;

  // Read returns the pre-write word when a write hits the same address.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder: accept in idle, fixed wait, one-cycle response
// with RV32I load extension and error flagging.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [2:0]        req_funct3,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned WordAw = ADDR_W - 2;
  localparam int unsigned Depth  = 1 << WordAw;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              rd_q, rd_d, wr_q, wr_d;

  logic              accept, enter_resp, in_idle, resp;
  logic              cur_rd, cur_wr, cur_err;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [2:0]        cur_funct3;
  logic              mem_en;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata, mem_rdata, load_val;
  logic [7:0]        load_byte;
  logic [15:0]       load_half;
  logic              resp_err;

  assign in_idle   = (state_q == StIdle);
  assign req_ready = in_idle && !reset;
  assign accept    = req_ready && (req_rd || req_wr);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    funct3_d   = funct3_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    enter_resp = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          funct3_d = req_funct3;
          rd_d     = req_rd;
          wr_d     = req_wr;
          cnt_d    = 4'(WAIT_CYC);
          if (WAIT_CYC == 0) begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d    = StResp;
          enter_resp = 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= 3'd0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
    end
  end

  // With zero wait the array is accessed on the accept edge, so use the live request.
  assign cur_rd     = in_idle ? req_rd     : rd_q;
  assign cur_wr     = in_idle ? req_wr     : wr_q;
  assign cur_addr   = in_idle ? req_addr   : addr_q;
  assign cur_wdata  = in_idle ? req_wdata  : wdata_q;
  assign cur_funct3 = in_idle ? req_funct3 : funct3_q;
  assign cur_err    = req_illegal(cur_rd, cur_wr, cur_funct3, cur_addr[1:0]);
  assign mem_en     = enter_resp && !reset;

  always_comb begin
    mem_be    = 4'b0000;
    mem_wdata = cur_wdata[31:0];
    if (cur_wr && !cur_err) begin
      case (cur_funct3)
        Funct3Sb: begin
          mem_be    = 4'b0001 << cur_addr[1:0];
          mem_wdata = {4{cur_wdata[7:0]}};
        end
        Funct3Sh: begin
          mem_be    = cur_addr[1] ? 4'b1100 : 4'b0011;
          mem_wdata = {2{cur_wdata[15:0]}};
        end
        Funct3Sw: mem_be = 4'b1111;
        default:  mem_be = 4'b0000;
      endcase
    end
  end

  dm_sram #(
    .Depth (Depth),
    .AddrW (WordAw)
  ) u_sram (
    .clk_i   (clk),
    .en_i    (mem_en),
    .be_i    (mem_be),
    .addr_i  (cur_addr[ADDR_W-1:2]),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

  assign load_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign load_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    load_val = mem_rdata;
    case (funct3_q)
      Funct3Lb:  load_val = {{24{load_byte[7]}}, load_byte};
      Funct3Lbu: load_val = {24'd0, load_byte};
      Funct3Lh:  load_val = {{16{load_half[15]}}, load_half};
      Funct3Lhu: load_val = {16'd0, load_half};
      default:   load_val = mem_rdata;
    endcase
  end

  assign resp      = (state_q == StResp) && !reset;
  assign resp_err  = req_illegal(rd_q, wr_q, funct3_q, addr_q[1:0]);
  assign rsp_valid = resp;
  assign rsp_err   = resp && resp_err;
  assign rsp_rdata = (resp && rd_q && !resp_err) ? DATA_W'(load_val) : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised bench for data_mem_responder: one instance with two wait cycles, one with none,
// each checked against a byte-addressed memory model.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_rd     [2];
  logic        req_wr     [2];
  logic [8:0]  req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [2:0]  req_funct3 [2];
  logic        req_ready  [2];
  logic        rsp_valid  [2];
  logic [31:0] rsp_rdata  [2];
  logic        rsp_err    [2];

  always #5 clk = ~clk;

  data_mem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYC(2)) u_dut_w2 (
    .clk        (clk),
    .reset      (reset),
    .req_rd     (req_rd[0]),
    .req_wr     (req_wr[0]),
    .req_addr   (req_addr[0]),
    .req_wdata  (req_wdata[0]),
    .req_funct3 (req_funct3[0]),
    .req_ready  (req_ready[0]),
    .rsp_valid  (rsp_valid[0]),
    .rsp_rdata  (rsp_rdata[0]),
    .rsp_err    (rsp_err[0])
  );

  data_mem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYC(0)) u_dut_w0 (
    .clk        (clk),
    .reset      (reset),
    .req_rd     (req_rd[1]),
    .req_wr     (req_wr[1]),
    .req_addr   (req_addr[1]),
    .req_wdata  (req_wdata[1]),
    .req_funct3 (req_funct3[1]),
    .req_ready  (req_ready[1]),
    .rsp_valid  (rsp_valid[1]),
    .rsp_rdata  (rsp_rdata[1]),
    .rsp_err    (rsp_err[1])
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [7:0]  model [2][512];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: access size from funct3, alignment by modulo, bytes gathered little-endian.
  task automatic predict(input int sel, input logic rd, input logic wr, input logic [8:0] a,
                         input logic [31:0] wd, input logic [2:0] f3,
                         output logic e_err, output logic [31:0] e_data);
    int sz;
    bit sgn;
    sz = 0;
    sgn = 0;
    if (rd && !wr) begin
      case (f3)
        3'd0: begin sz = 1; sgn = 1; end
        3'd1: begin sz = 2; sgn = 1; end
        3'd2: sz = 4;
        3'd4: sz = 1;
        3'd5: sz = 2;
        default: sz = 0;
      endcase
    end else if (wr && !rd) begin
      case (f3)
        3'd0: sz = 1;
        3'd1: sz = 2;
        3'd2: sz = 4;
        default: sz = 0;
      endcase
    end
    if (sz == 0) e_err = 1'b1;
    else e_err = (int'(a) % sz) != 0;
    e_data = 32'd0;
    if (!e_err && rd) begin
      for (int i = 0; i < sz; i++) e_data = e_data | (32'(model[sel][int'(a) + i]) << (8 * i));
      if (sgn && e_data[8*sz-1]) begin
        for (int i = sz; i < 4; i++) e_data[8*i +: 8] = 8'hFF;
      end
    end
    if (!e_err && wr) begin
      for (int i = 0; i < sz; i++) model[sel][int'(a) + i] = wd[8*i +: 8];
    end
  endtask

  task automatic tx(input int sel, input logic rd, input logic wr, input logic [8:0] a,
                    input logic [31:0] wd, input logic [2:0] f3, input bit hold,
                    output logic [31:0] got_d, output logic got_e);
    logic        e_err;
    logic [31:0] e_data;
    int          lat, nv, wc;
    wc = (sel == 0) ? 2 : 0;
    predict(sel, rd, wr, a, wd, f3, e_err, e_data);
    @(negedge clk);
    check("ready", 32'(req_ready[sel]), 32'd1);
    req_rd[sel]     = rd;
    req_wr[sel]     = wr;
    req_addr[sel]   = a;
    req_wdata[sel]  = wd;
    req_funct3[sel] = f3;
    @(posedge clk);
    #1;
    if (!hold) begin
      req_rd[sel] = 1'b0;
      req_wr[sel] = 1'b0;
    end
    lat = 0;
    nv = 0;
    got_d = 32'd0;
    got_e = 1'b0;
    for (int c = 1; c <= wc + 3; c++) begin
      @(negedge clk);
      if (rsp_valid[sel]) begin
        nv++;
        if (lat == 0) begin
          lat = c;
          got_d = rsp_rdata[sel];
          got_e = rsp_err[sel];
        end
        req_rd[sel] = 1'b0;
        req_wr[sel] = 1'b0;
      end else if (hold && req_rd[sel] | req_wr[sel]) begin
        // Scramble the still-asserted request; it must have no effect.
        req_addr[sel]   = 9'($urandom);
        req_wdata[sel]  = $urandom;
        req_funct3[sel] = 3'($urandom);
      end
    end
    req_rd[sel] = 1'b0;
    req_wr[sel] = 1'b0;
    check("latency", 32'(lat), 32'(wc + 1));
    check("valid_count", 32'(nv), 32'd1);
    check("err", 32'(got_e), 32'(e_err));
    check("rdata", got_d, e_data);
  endtask

  logic [31:0] rdv, prev;
  logic        erv;

  initial begin
    reset = 1'b1;
    for (int s = 0; s < 2; s++) begin
      req_rd[s] = 0; req_wr[s] = 0; req_addr[s] = 0; req_wdata[s] = 0; req_funct3[s] = 0;
    end
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("rst_ready", 32'(req_ready[s]), 32'd0);
      check("rst_valid", 32'(rsp_valid[s]), 32'd0);
      check("rst_rdata", rsp_rdata[s], 32'd0);
      check("rst_err", 32'(rsp_err[s]), 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst0", 32'(req_ready[0]), 32'd1);
    check("ready_after_rst1", 32'(req_ready[1]), 32'd1);

    // Give every word a known value in both instances.
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 128; w++) tx(s, 0, 1, 9'(w * 4), $urandom, 3'd2, 0, rdv, erv);

    // Directed scenarios on the two-wait instance.
    tx(0, 0, 1, 9'h010, 32'hDEADBEEF, 3'd2, 0, rdv, erv);
    tx(0, 1, 0, 9'h010, 32'd0, 3'd2, 0, rdv, erv);
    check("lw_deadbeef", rdv, 32'hDEADBEEF);
    tx(0, 1, 0, 9'h013, 32'd0, 3'd0, 0, rdv, erv);
    check("lb_sign", rdv, 32'hFFFFFFDE);
    tx(0, 1, 0, 9'h013, 32'd0, 3'd4, 0, rdv, erv);
    check("lbu_zero", rdv, 32'h000000DE);
    tx(0, 0, 1, 9'h012, 32'h00001234, 3'd1, 0, rdv, erv);
    tx(0, 1, 0, 9'h010, 32'd0, 3'd2, 0, rdv, erv);
    check("sh_merge", rdv, 32'h1234BEEF);
    tx(0, 1, 0, 9'h011, 32'd0, 3'd2, 0, rdv, erv);
    check("lw_misalign", 32'(erv), 32'd1);
    tx(0, 0, 1, 9'h013, 32'hFFFFFFFF, 3'd1, 0, rdv, erv);
    check("sh_misalign", 32'(erv), 32'd1);
    tx(0, 1, 1, 9'h010, 32'h0BADF00D, 3'd2, 0, rdv, erv);
    check("rd_wr_both", 32'(erv), 32'd1);
    tx(0, 1, 0, 9'h010, 32'd0, 3'd2, 0, rdv, erv);
    check("word_unchanged", rdv, 32'h1234BEEF);

    // Store abandoned by reset during the wait.
    prev = {model[0][9'h023], model[0][9'h022], model[0][9'h021], model[0][9'h020]};
    @(negedge clk);
    req_wr[0] = 1; req_addr[0] = 9'h020; req_wdata[0] = 32'h55AA55AA; req_funct3[0] = 3'd2;
    @(posedge clk);
    #1;
    req_wr[0] = 0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("wrst_valid", 32'(rsp_valid[0]), 32'd0);
    check("wrst_ready", 32'(req_ready[0]), 32'd0);
    @(negedge clk);
    check("wrst_valid2", 32'(rsp_valid[0]), 32'd0);
    check("wrst_rdata", rsp_rdata[0], 32'd0);
    check("wrst_err", 32'(rsp_err[0]), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_wrst", 32'(req_ready[0]), 32'd1);
    tx(0, 1, 0, 9'h020, 32'd0, 3'd2, 0, rdv, erv);
    check("store_abandoned", rdv, prev);

    // Held request during wait, top word round trip, then the zero-wait instance.
    tx(0, 0, 1, 9'h1FC, 32'hA5C3_0F96, 3'd2, 1, rdv, erv);
    tx(0, 1, 0, 9'h1FC, 32'd0, 3'd2, 1, rdv, erv);
    check("top_word", rdv, 32'hA5C30F96);
    tx(1, 0, 1, 9'h1FC, 32'h1357_9BDF, 3'd2, 0, rdv, erv);
    tx(1, 1, 0, 9'h1FC, 32'd0, 3'd2, 0, rdv, erv);
    check("top_word_w0", rdv, 32'h13579BDF);

    repeat (300) begin
      int sel, kind;
      logic rd, wr;
      logic [2:0] f3;
      logic [8:0] a;
      sel  = int'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 9));
      rd   = (kind < 5) || (kind == 9);
      wr   = (kind >= 5);
      f3   = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
        int pick;
        pick = int'($urandom_range(0, 4));
        f3 = (pick == 3) ? 3'd4 : (pick == 4) ? 3'd5 : 3'(pick);
      end
      a = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 1) == 0) a = a & 9'h1FC;
      tx(sel, rd, wr, a, $urandom, f3, $urandom_range(0, 3) == 0, rdv, erv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DATA_W, default 32, is the data word width.
REQ-002 Parameter ADDR_W, default 9, is the byte address width (512-byte space, 128 words).
REQ-003 Parameter WAIT_CYC, default 2, is the number of wait cycles between accept and response (legal range 0..15).
REQ-004 clk  input  1  is the single clock; all state changes on its rising edge.
REQ-005 reset  input  1  is the synchronous, active-high reset.
REQ-006 req_rd  input  1  is the load request.
REQ-007 req_wr  input  1  is the store request.
REQ-008 req_addr  input  ADDR_W  is the byte address.
REQ-009 req_wdata  input  DATA_W  is the store data, with the value in the low bits.
REQ-010 req_funct3  input  3  is the access size/sign code (RV32I load/store funct3).
REQ-011 req_ready  output  1  signals that the block can accept a request this cycle.
REQ-012 rsp_valid  output  1  is a one-cycle response strobe.
REQ-013 rsp_rdata  output  DATA_W  is the extended load data; it is 0 for stores and errors.
REQ-014 rsp_err  output  1  flags a misaligned, illegal or conflicting request; it is valid with rsp_valid.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 Accept SHALL occur on a cycle with req_ready=1 and (req_rd or req_wr); it captures addr, wdata, funct3 and op, and loads the wait counter with WAIT_CYC.
REQ-017 After accept: if WAIT_CYC=0, go to RESP; otherwise go to WAIT and decrement each cycle, entering RESP when the counter reaches 0.
REQ-018 rsp_valid SHALL assert exactly WAIT_CYC+1 cycles after the accept cycle, for exactly one cycle (RESP); the next state is IDLE; there is no backpressure.
REQ-019 Request inputs SHALL be ignored outside IDLE, with no queuing.
REQ-020 Memory write and read-data capture SHALL occur on the edge entering RESP; a load issued after a store observes the stored data.
REQ-021 Loads: LB/LBU select byte addr[1:0]; LH/LHU select halfword addr[1]; LW takes the whole word. LB/LH sign-extend; LBU/LHU zero-extend.
REQ-022 Stores: SB/SH/SW SHALL update only the addressed byte lanes; other bytes are unchanged.
REQ-023 rsp_err=1 with no memory change and rsp_rdata=0 SHALL result from: halfword with addr[0]=1; word with addr[1:0]!=0; illegal funct3 (load 011/110/111, store >=011); or req_rd and req_wr both 1.
REQ-024 An erroneous request SHALL follow the same timing as a legal one.
REQ-025 The address is used directly, word index addr[ADDR_W-1:2]; there is no wrap beyond 0x1FF, and 0x1FC is a legal word.

Reset
REQ-026 While reset=1: state IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
REQ-027 In the first cycle after reset deasserts, req_ready SHALL be 1.
REQ-028 Reset during WAIT SHALL abandon the request; a pending store is not committed.
REQ-029 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-030 The shared package mem_pkg SHALL hold the funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW) and the state enum type.
REQ-031 A single sub-module dm_sram SHALL hold a 128 x 32 array with a 4-bit byte-enable write port and a synchronous read port; the FSM, extension and error logic stay in the parent.

Verification
REQ-032 SW 0xDEADBEEF @0x010, then LW @0x010 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid exactly 3 cycles after accept (WAIT_CYC=2).
REQ-033 LB @0x013 -> 0xFFFFFFDE; LBU @0x013 -> 0x000000DE; then SH 0x1234 @0x012 and LW @0x010 -> 0x1234BEEF.
REQ-034 LW @0x011, SH @0x013 and req_rd=req_wr=1 -> rsp_err=1, rsp_rdata=0, memory word @0x010 unchanged.
REQ-035 SW 0x55AA55AA @0x020 with reset pulsed during WAIT -> the following LW @0x020 returns the prior value, and req_ready=1 the cycle after reset drops.
REQ-036 Second request asserted during WAIT -> ignored (one rsp_valid only); SW/LW @0x1FC round-trip correct; repeat with WAIT_CYC=0 -> rsp_valid 1 cycle after accept.
